// File: rtl/axil_cfg_pkg.sv
// Shared types and constants for the AXI4-Lite configuration arbiter.
package axil_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_RESP,
    DONE
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG_OFS0 = 4'h0;
  localparam logic [3:0] REG_OFS1 = 4'h4;
  localparam logic [3:0] REG_OFS2 = 4'h8;
  localparam logic [3:0] REG_OFS3 = 4'hC;

  function automatic logic [1:0] oneHot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a tie
// and moves to the other requester whenever a grant is issued.
module rr_arb2
  import axil_cfg_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstN,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant,
  output logic       o_idx
);

  logic r_prio;
  logic w_idx;

  assign w_idx   = (i_req == 2'b11) ? r_prio : i_req[1];
  assign o_idx   = w_idx;
  assign o_grant = (i_en && (|i_req)) ? oneHot2(w_idx) : 2'b00;

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_prio <= 1'b0;
    end else if (|o_grant) begin
      r_prio <= ~w_idx;
    end
  end

endmodule

// File: rtl/axil_cfg_arbiter.sv
// Two-requester, single-outstanding AXI4-Lite master for configuration registers.
// Optional watchdog enabled by defining AXIL_ARB_TIMEOUT_EN.
module axil_cfg_arbiter
  import axil_cfg_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(3));

  arb_state_e          r_state, w_next;
  logic                r_idx;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_resp;
  logic                r_awDone, r_wDone;
  logic [1:0]          w_grant;
  logic                w_gntIdx;
  logic                w_toLimit;
  logic                w_toFire;

  rr_arb2 u_rrArb (
    .i_clk   (ACLK),
    .i_rstN  (ARESETN),
    .i_en    (ARESETN && (r_state == IDLE)),
    .i_req   (req_valid),
    .o_grant (w_grant),
    .o_idx   (w_gntIdx)
  );

  assign req_ready     = w_grant;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign rsp_rdata     = (r_state == DONE) ? r_rdata : '0;
  assign rsp_resp      = (r_state == DONE) ? r_resp : RESP_OKAY;

  always_comb begin
    w_next        = r_state;
    w_toFire      = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    rsp_valid     = 2'b00;
    case (r_state)
      IDLE: begin
        if (|w_grant) w_next = req_write[w_gntIdx] ? WR : RD;
      end
      WR: begin
        M_AXI_AWVALID = !r_awDone;
        M_AXI_WVALID  = !r_wDone;
        if ((r_awDone || M_AXI_AWREADY) && (r_wDone || M_AXI_WREADY)) w_next = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) w_next = DONE;
      end
      RD: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) w_next = RD_RESP;
      end
      RD_RESP: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) w_next = DONE;
      end
      DONE: begin
        rsp_valid = oneHot2(r_idx);
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // A completing handshake always wins over the watchdog in the same cycle.
    if (w_toLimit && (w_next == r_state) && (r_state inside {WR, WR_RESP, RD, RD_RESP})) begin
      w_next   = DONE;
      w_toFire = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state  <= IDLE;
      r_idx    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_resp   <= RESP_OKAY;
      r_awDone <= 1'b0;
      r_wDone  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (|w_grant) begin
        r_idx    <= w_gntIdx;
        r_addr   <= (w_gntIdx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0]) & ADDR_MASK;
        r_wdata  <= w_gntIdx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        r_awDone <= 1'b0;
        r_wDone  <= 1'b0;
      end
      if (r_state == WR) begin
        if (M_AXI_AWREADY) r_awDone <= 1'b1;
        if (M_AXI_WREADY)  r_wDone  <= 1'b1;
      end
      if (w_toFire) begin
        r_rdata <= '0;
        r_resp  <= RESP_SLVERR;
      end else if ((r_state == WR_RESP) && M_AXI_BVALID) begin
        r_rdata <= '0;
        r_resp  <= M_AXI_BRESP;
      end else if ((r_state == RD_RESP) && M_AXI_RVALID) begin
        r_rdata <= M_AXI_RDATA;
        r_resp  <= M_AXI_RRESP;
      end
    end
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_toCount;

  assign w_toLimit = (r_toCount >= TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK) begin
    if (!ARESETN || (r_state == IDLE) || (r_state == DONE)) begin
      r_toCount <= '0;
    end else if (!w_toLimit) begin
      r_toCount <= r_toCount + TO_W'(1);
    end
  end
`else
  assign w_toLimit = 1'b0;
`endif

endmodule
